svf_sample_feeder: RTL

Source-side companion to the 8-bit state variable filter: it drives the filter's input protocol. Every DIV clocks it does three things: mixes three signed 8-bit voice samples into a saturated filter-input sample and a saturated bypass sample, emits a one-cycle `sample_valid` strobe, and presents the filter coefficients `alpha1`/`alpha2`. `alpha1` slews toward a register-written target to avoid zipper noise. It sits between the voice generators and the filter, and owns the audio sample rate.

---
 rtl/svf_sample_feeder.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/svf_sample_feeder.sv
// Source-side feeder for the 8-bit state variable filter: mixes three voices into
// saturated filter/bypass samples every DIV clocks and presents slewed coefficients.
module svf_sample_feeder #(
  parameter int DIV       = 15,
  parameter int SLEW_STEP = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic signed [7:0] voice0,
  input  logic signed [7:0] voice1,
  input  logic signed [7:0] voice2,
  input  logic [2:0]        filt_en,
  input  logic [10:0]       fc_target,
  input  logic [1:0]        res_target,
  input  logic              reg_wr,
  output logic signed [7:0] audio_in,
  output logic signed [7:0] bypass_out,
  output logic              sample_valid,
  output logic [10:0]       alpha1,
  output logic [1:0]        alpha2
);

  localparam logic [11:0]        CNT_LAST = 12'(DIV - 1);
  localparam logic [10:0]        STEP_U   = 11'(SLEW_STEP);
  localparam logic signed [11:0] STEP_POS = $signed({1'b0, STEP_U});
  localparam logic signed [11:0] STEP_NEG = 12'sd0 - STEP_POS;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC0 = 3'd1,
    ACC1 = 3'd2,
    ACC2 = 3'd3,
    EMIT = 3'd4
  } state_t;

  function automatic logic signed [7:0] sat8(input logic signed [9:0] v);
    logic signed [7:0] r;
    if (v > 10'sd127) begin
      r = 8'sh7f;
    end else if (v < -10'sd128) begin
      r = 8'sh80;
    end else begin
      r = v[7:0];
    end
    return r;
  endfunction

  // Bounded step toward the target; never overshoots so alpha1 stays in 0..2047.
  function automatic logic [10:0] slew(input logic [10:0] cur, input logic [10:0] tgt);
    logic signed [11:0] diff;
    logic [10:0]        r;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (diff > STEP_POS) begin
      r = cur + STEP_U;
    end else if (diff < STEP_NEG) begin
      r = cur - STEP_U;
    end else begin
      r = tgt;
    end
    return r;
  endfunction

  logic [11:0]       cnt_r;
  state_t            state_r;
  state_t            state_s;
  logic              snap_s;
  logic              acc_en_s;
  logic              emit_s;
  logic [1:0]        acc_sel_s;
  logic signed [7:0] snap_v0_r;
  logic signed [7:0] snap_v1_r;
  logic signed [7:0] snap_v2_r;
  logic [2:0]        snap_fe_r;
  logic signed [9:0] filt_acc_r;
  logic signed [9:0] byp_acc_r;
  logic [10:0]       shadow_fc_r;
  logic [1:0]        shadow_res_r;
  logic signed [7:0] voice_s;
  logic              route_s;
  logic signed [9:0] voice_ext_s;

  assign snap_s = (cnt_r == CNT_LAST);

  // Free-running sample-rate divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 12'd0;
    end else if (snap_s) begin
      cnt_r <= 12'd0;
    end else begin
      cnt_r <= cnt_r + 12'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (snap_s) begin
          state_s = ACC0;
        end else begin
          state_s = IDLE;
        end
      end
      ACC0:    state_s = ACC1;
      ACC1:    state_s = ACC2;
      ACC2:    state_s = EMIT;
      EMIT:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // FSM control outputs.
  always_comb begin
    acc_en_s  = 1'b0;
    acc_sel_s = 2'd0;
    emit_s    = 1'b0;
    case (state_r)
      ACC0: begin
        acc_en_s  = 1'b1;
        acc_sel_s = 2'd0;
      end
      ACC1: begin
        acc_en_s  = 1'b1;
        acc_sel_s = 2'd1;
      end
      ACC2: begin
        acc_en_s  = 1'b1;
        acc_sel_s = 2'd2;
      end
      EMIT:    emit_s = 1'b1;
      default: begin
        acc_en_s  = 1'b0;
        acc_sel_s = 2'd0;
        emit_s    = 1'b0;
      end
    endcase
  end

  // Select the snapshot voice and its routing bit for the current ACC state.
  always_comb begin
    voice_s = 8'sd0;
    route_s = 1'b0;
    case (acc_sel_s)
      2'd0: begin
        voice_s = snap_v0_r;
        route_s = snap_fe_r[0];
      end
      2'd1: begin
        voice_s = snap_v1_r;
        route_s = snap_fe_r[1];
      end
      2'd2: begin
        voice_s = snap_v2_r;
        route_s = snap_fe_r[2];
      end
      default: begin
        voice_s = 8'sd0;
        route_s = 1'b0;
      end
    endcase
  end

  assign voice_ext_s = {{2{voice_s[7]}}, voice_s};

  // Voice and routing snapshot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_v0_r <= 8'sd0;
      snap_v1_r <= 8'sd0;
      snap_v2_r <= 8'sd0;
      snap_fe_r <= 3'd0;
    end else if (snap_s) begin
      snap_v0_r <= voice0;
      snap_v1_r <= voice1;
      snap_v2_r <= voice2;
      snap_fe_r <= filt_en;
    end else begin
      snap_v0_r <= snap_v0_r;
      snap_v1_r <= snap_v1_r;
      snap_v2_r <= snap_v2_r;
      snap_fe_r <= snap_fe_r;
    end
  end

  // Mixing accumulators; 10 bits hold three full-scale voices without wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_acc_r <= 10'sd0;
      byp_acc_r  <= 10'sd0;
    end else if (snap_s) begin
      filt_acc_r <= 10'sd0;
      byp_acc_r  <= 10'sd0;
    end else if (acc_en_s) begin
      if (route_s) begin
        filt_acc_r <= filt_acc_r + voice_ext_s;
      end else begin
        byp_acc_r <= byp_acc_r + voice_ext_s;
      end
    end else begin
      filt_acc_r <= filt_acc_r;
      byp_acc_r  <= byp_acc_r;
    end
  end

  // Coefficient shadow registers, writable in any state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_fc_r  <= 11'd0;
      shadow_res_r <= 2'd0;
    end else if (reg_wr) begin
      shadow_fc_r  <= fc_target;
      shadow_res_r <= res_target;
    end else begin
      shadow_fc_r  <= shadow_fc_r;
      shadow_res_r <= shadow_res_r;
    end
  end

  // Output stage: everything updates together on the edge leaving EMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_valid <= 1'b0;
      audio_in     <= 8'sd0;
      bypass_out   <= 8'sd0;
      alpha1       <= 11'd0;
      alpha2       <= 2'd0;
    end else begin
      sample_valid <= emit_s;
      if (emit_s) begin
        audio_in   <= sat8(filt_acc_r);
        bypass_out <= sat8(byp_acc_r);
        alpha1     <= slew(alpha1, shadow_fc_r);
        alpha2     <= shadow_res_r;
      end else begin
        audio_in   <= audio_in;
        bypass_out <= bypass_out;
        alpha1     <= alpha1;
        alpha2     <= alpha2;
      end
    end
  end

endmodule
